video_frame_mux: RTL and testbench

Frame-aligned N:1 arbiter for pixel streams using valid/ready with sof/eof/eol sideband. Grants one source per frame in round-robin order, forwards that frame intact to a single downstream stream port, then rearbitrates. Placed between several frame sources (pattern generators, sensor front ends) and the shared downstream video pipeline, so sources can be switched without tearing a frame.

---
 rtl/video_stream_pkg.sv | 20 ++
 rtl/video_frame_mux_rr_arbiter.sv | 37 +++
 rtl/video_frame_mux.sv | 233 +++++++++++++++++++++++
 tb/tb_video_frame_mux.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// video_stream_pkg
//   Definitions shared by the frame-aligned stream mux and its arbiter:
//   - frame_state_t : FSM encoding for IDLE / HUNT / PASS
//   - SRC_IDX_W     : width of a source index (covers up to 4 sources)
//   - beat_width()  : bits carried by one stream beat
package video_stream_pkg;

    localparam int SRC_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        PASS = 2'd2
    } frame_state_t;

    function automatic int beat_width(input int pixel_bitwidth, input int pixel_num);
        return pixel_bitwidth * pixel_num;
    endfunction

endpackage

// File: rtl/video_frame_mux_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. The search starts at last_grant+1 and
//   wraps modulo SRC_NUM; the first requesting source wins. The caller
//   registers the result.
// Ports:
//   req        in  SRC_NUM    request vector
//   last_grant in  SRC_IDX_W  index granted last time
//   grant      out SRC_IDX_W  chosen index (0 when nothing is found)
//   found      out 1          at least one request was present
module rr_arbiter
    import video_stream_pkg::*;
#(
    parameter int SRC_NUM = 2
) (
    input  logic [SRC_NUM-1:0]   req,
    input  logic [SRC_IDX_W-1:0] last_grant,
    output logic [SRC_IDX_W-1:0] grant,
    output logic                 found
);

    // Outer loop walks the priority order, inner loop matches the rotated
    // position against a constant bit index so no variable bit-select is needed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= SRC_NUM; k++) begin
            for (int unsigned i = 0; i < SRC_NUM; i++) begin
                if (!found && req[i] &&
                    (i == ((32'(last_grant) + k) % 32'(SRC_NUM)))) begin
                    found = 1'b1;
                    grant = SRC_IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/video_frame_mux.sv
// video_frame_mux
//   Frame-aligned N:1 arbiter for valid/ready pixel streams with sof/eof/eol
//   sideband. One source is granted per frame in round-robin order; its frame
//   is forwarded intact through a single output register, then the mux
//   rearbitrates.
//
//   Optional build macro VIDEO_MUX_DROP_IDLE_EN: when defined, sources that
//   are not granted (and every source while IDLE) see ready=1 and their beats
//   are discarded; when undefined they are back-pressured until granted.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_valid/ready  [SRC_NUM]  per-source handshake
//   s_axis_data                    per-source beat, source i in slice i
//   s_axis_sof/eof/eol  [SRC_NUM]  per-source sideband
//   src_enable          [SRC_NUM]  mask for new grants
//   m_axis_*                       downstream stream port (registered)
//   cur_src                        granted source index, held after a frame
//   frame_busy                     high while in HUNT or PASS
//   frame_err                      one-cycle pulse on hunt timeout or early sof
module video_frame_mux
    import video_stream_pkg::*;
#(
    parameter int PIXEL_BITWIDTH = 8,
    parameter int PIXEL_NUM      = 1,
    parameter int SRC_NUM        = 2,
    parameter int HUNT_TIMEOUT   = 4096
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [SRC_NUM-1:0]                          s_axis_valid,
    output logic [SRC_NUM-1:0]                          s_axis_ready,
    input  logic [SRC_NUM*PIXEL_BITWIDTH*PIXEL_NUM-1:0] s_axis_data,
    input  logic [SRC_NUM-1:0]                          s_axis_sof,
    input  logic [SRC_NUM-1:0]                          s_axis_eof,
    input  logic [SRC_NUM-1:0]                          s_axis_eol,
    input  logic [SRC_NUM-1:0]                          src_enable,
    input  logic                                        m_axis_ready,
    output logic                                        m_axis_valid,
    output logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0]         m_axis_data,
    output logic                                        m_axis_sof,
    output logic                                        m_axis_eof,
    output logic                                        m_axis_eol,
    output logic [SRC_IDX_W-1:0]                        cur_src,
    output logic                                        frame_busy,
    output logic                                        frame_err
);

    localparam int BEAT_W     = beat_width(PIXEL_BITWIDTH, PIXEL_NUM);
    localparam int HUNT_CNT_W = $clog2(HUNT_TIMEOUT + 1);
    localparam logic [HUNT_CNT_W-1:0] HUNT_LAST = HUNT_CNT_W'(HUNT_TIMEOUT - 1);

`ifdef VIDEO_MUX_DROP_IDLE_EN
    localparam logic UNGRANTED_READY = 1'b1;
`else
    localparam logic UNGRANTED_READY = 1'b0;
`endif

    frame_state_t state, next_state;

    logic [HUNT_CNT_W-1:0] hunt_cnt;
    logic                  eof_seen;

    // Granted-source view
    logic              sel_valid;
    logic [BEAT_W-1:0] sel_data;
    logic              sel_sof, sel_eof, sel_eol;
    logic [SRC_NUM-1:0] grant_mask;

    // Arbiter
    logic [SRC_NUM-1:0]   arb_req;
    logic [SRC_IDX_W-1:0] arb_grant;
    logic                 arb_found;

    // FSM decisions
    logic               out_free;
    logic               arb_take;
    logic               fwd;
    logic               frame_end;
    logic               hunt_expired;
    logic               restart_err;
    logic [SRC_NUM-1:0] ready_c;

    assign arb_req = src_enable & s_axis_valid;

    rr_arbiter #(
        .SRC_NUM(SRC_NUM)
    ) u_rr_arbiter (
        .req        (arb_req),
        .last_grant (cur_src),
        .grant      (arb_grant),
        .found      (arb_found)
    );

    always_comb begin
        sel_valid  = 1'b0;
        sel_data   = '0;
        sel_sof    = 1'b0;
        sel_eof    = 1'b0;
        sel_eol    = 1'b0;
        grant_mask = '0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            if (cur_src == SRC_IDX_W'(i)) begin
                grant_mask[i] = 1'b1;
                sel_valid     = s_axis_valid[i];
                sel_data      = s_axis_data[i*BEAT_W +: BEAT_W];
                sel_sof       = s_axis_sof[i];
                sel_eof       = s_axis_eof[i];
                sel_eol       = s_axis_eol[i];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = !m_axis_valid || m_axis_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        ready_c      = {SRC_NUM{UNGRANTED_READY}};
        arb_take     = 1'b0;
        fwd          = 1'b0;
        frame_end    = 1'b0;
        hunt_expired = 1'b0;
        restart_err  = 1'b0;

        // While hunting the granted source is normally always ready; the only
        // time it is held off is when a stalled beat of the previous frame
        // still occupies the output register, so a sof cannot be lost.
        if (state != IDLE) begin
            for (int unsigned i = 0; i < SRC_NUM; i++) begin
                if (grant_mask[i]) begin
                    ready_c[i] = out_free;
                end
            end
        end

        case (state)
            IDLE: begin
                if (arb_found) begin
                    arb_take   = 1'b1;
                    next_state = HUNT;
                end
            end
            HUNT: begin
                if (sel_valid && out_free && sel_sof) begin
                    fwd = 1'b1;
                    if (sel_eof && sel_eol) begin
                        frame_end  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = PASS;
                    end
                end else if (hunt_cnt == HUNT_LAST) begin
                    hunt_expired = 1'b1;
                    next_state   = IDLE;
                end
            end
            PASS: begin
                if (sel_valid && out_free) begin
                    fwd         = 1'b1;
                    restart_err = sel_sof;
                    // An early sof restarts the frame, so an eof seen before
                    // it no longer counts toward ending this frame.
                    if (sel_eol && (sel_eof || (eof_seen && !sel_sof))) begin
                        frame_end  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign s_axis_ready = ready_c;
    assign frame_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_src      <= SRC_IDX_W'(SRC_NUM - 1);
            hunt_cnt     <= '0;
            eof_seen     <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_sof   <= 1'b0;
            m_axis_eof   <= 1'b0;
            m_axis_eol   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (arb_take) begin
                cur_src <= arb_grant;
            end

            if ((state == HUNT) && (next_state == HUNT)) begin
                hunt_cnt <= hunt_cnt + HUNT_CNT_W'(1);
            end else begin
                hunt_cnt <= '0;
            end

            if (fwd) begin
                if (frame_end) begin
                    eof_seen <= 1'b0;
                end else if (sel_sof) begin
                    eof_seen <= sel_eof;
                end else begin
                    eof_seen <= eof_seen | sel_eof;
                end
            end

            if (out_free) begin
                m_axis_valid <= fwd;
                if (fwd) begin
                    m_axis_data <= sel_data;
                    m_axis_sof  <= sel_sof;
                    m_axis_eof  <= sel_eof;
                    m_axis_eol  <= sel_eol;
                end
            end

            frame_err <= hunt_expired | restart_err;
        end
    end

endmodule

// File: tb/tb_video_frame_mux.sv
// tb_video_frame_mux
//   Directed bench for video_frame_mux with two 8-bit sources and a hunt
//   timeout of 16 cycles. Each source is fed from a beat queue; output beats
//   are collected with the cycle they were accepted downstream.
module tb_video_frame_mux;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       eol;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_valid, s_ready, s_sof, s_eof, s_eol, src_enable;
    logic [15:0] s_data;
    logic        m_ready, m_valid, m_sof, m_eof, m_eol;
    logic [7:0]  m_data;
    logic [1:0]  cur_src;
    logic        frame_busy, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int sof_hs_cyc = -1;

    beat_t q0[$], q1[$], out_q[$];
    int    out_cyc[$];

    video_frame_mux #(
        .PIXEL_BITWIDTH(8),
        .PIXEL_NUM(1),
        .SRC_NUM(2),
        .HUNT_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_data  (s_data),
        .s_axis_sof   (s_sof),
        .s_axis_eof   (s_eof),
        .s_axis_eol   (s_eol),
        .src_enable   (src_enable),
        .m_axis_ready (m_ready),
        .m_axis_valid (m_valid),
        .m_axis_data  (m_data),
        .m_axis_sof   (m_sof),
        .m_axis_eof   (m_eof),
        .m_axis_eol   (m_eol),
        .cur_src      (cur_src),
        .frame_busy   (frame_busy),
        .frame_err    (frame_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source driver: handshake sampled mid-cycle, queue advanced after the edge.
    initial begin
        logic [1:0] hs;
        s_valid = '0; s_data = '0; s_sof = '0; s_eof = '0; s_eol = '0;
        forever begin
            @(negedge clk);
            hs = s_valid & s_ready;
            if (hs[0] && q0.size() > 0 && q0[0].sof) sof_hs_cyc = cyc;
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            s_valid[0] = (q0.size() > 0);
            s_valid[1] = (q1.size() > 0);
            if (q0.size() > 0) begin
                s_data[7:0] = q0[0].d; s_sof[0] = q0[0].sof; s_eof[0] = q0[0].eof; s_eol[0] = q0[0].eol;
            end
            if (q1.size() > 0) begin
                s_data[15:8] = q1[0].d; s_sof[1] = q1[0].sof; s_eof[1] = q1[0].eof; s_eol[1] = q1[0].eol;
            end
        end
    end

    // Output collector
    initial forever begin
        @(negedge clk);
        if (!rst && m_valid && m_ready) begin
            out_q.push_back('{m_data, m_sof, m_eof, m_eol});
            out_cyc.push_back(cyc);
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Expected beat k of a 4x3 frame: sof on beat 0, eol on the last beat of
    // each line, eof on beat eof_k.
    function automatic beat_t exp_beat(input logic [7:0] base, input int eof_k, input int k);
        beat_t b;
        b.d   = base + 8'(k);
        b.sof = (k == 0);
        b.eof = (k == eof_k);
        b.eol = ((k % 4) == 3);
        return b;
    endfunction

    task automatic push_frame(input int src, input logic [7:0] base, input int eof_k);
        for (int k = 0; k < 12; k++) begin
            if (src == 0) q0.push_back(exp_beat(base, eof_k, k));
            else          q1.push_back(exp_beat(base, eof_k, k));
        end
    endtask

    task automatic push_junk(input int src, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (src == 0) q0.push_back('{base + 8'(k), 1'b0, 1'b0, 1'b0});
            else          q1.push_back('{base + 8'(k), 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int t = 0; t < budget && out_q.size() < n; t++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; src_enable = 2'b11; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        n_checks++; if ({m_sof, m_eof, m_eol} !== 3'b000) begin n_fail++; $display("FAIL reset_sideband: got %b expected 000", {m_sof, m_eof, m_eol}); end
        n_checks++; if (cur_src !== 2'd1) begin n_fail++; $display("FAIL reset_cur_src: got %0d expected 1", cur_src); end
        n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", frame_busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        n_checks++; if (s_ready !== 2'b00) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 00", s_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        out_q.delete(); out_cyc.delete(); err_cnt = 0;
        push_frame(0, 8'h00, 11); push_frame(0, 8'h00, 11);
        push_frame(1, 8'h10, 8);  push_frame(1, 8'h10, 8);
        wait_out(48, 400);
        n_checks++; if (out_q.size() != 48) begin n_fail++; $display("FAIL rr_count: got %0d beats expected 48", out_q.size()); end
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 12; k++) begin
                beat_t got, exp;
                got = (f*12 + k < out_q.size()) ? out_q[f*12 + k] : '0;
                exp = exp_beat((f % 2) ? 8'h10 : 8'h00, (f % 2) ? 8 : 11, k);
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL rr_beat f%0d k%0d: got %h expected %h", f, k, got, exp); end
            end
        end
        if (out_cyc.size() >= 13) begin
            n_checks++; if (out_cyc[11] - out_cyc[0] != 11) begin n_fail++; $display("FAIL rr_throughput: got %0d cycles expected 11", out_cyc[11] - out_cyc[0]); end
            n_checks++; if (out_cyc[12] - out_cyc[11] != 2) begin n_fail++; $display("FAIL rr_gap: got %0d cycles expected 2", out_cyc[12] - out_cyc[11]); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL rr_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_hunt_drop;
        out_q.delete(); out_cyc.delete(); err_cnt = 0; sof_hs_cyc = -1;
        push_junk(0, 8'hA0, 10);
        push_frame(0, 8'h00, 11);
        wait_out(12, 200);
        repeat (5) @(negedge clk);
        n_checks++; if (out_q.size() != 12) begin n_fail++; $display("FAIL drop_count: got %0d beats expected 12", out_q.size()); end
        for (int k = 0; k < 12; k++) begin
            beat_t got, exp;
            got = (k < out_q.size()) ? out_q[k] : '0;
            exp = exp_beat(8'h00, 11, k);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL drop_beat k%0d: got %h expected %h", k, got, exp); end
        end
        if (out_cyc.size() > 0) begin
            n_checks++; if (out_cyc[0] != sof_hs_cyc + 1) begin n_fail++; $display("FAIL drop_latency: got cycle %0d expected %0d", out_cyc[0], sof_hs_cyc + 1); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL drop_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_hunt_timeout;
        int h, e;
        h = -1; e = -1;
        out_q.delete(); out_cyc.delete(); err_cnt = 0;
        @(posedge clk); #1;
        src_enable = 2'b01;
        push_junk(0, 8'hC0, 40);
        for (int t = 0; t < 20 && h < 0; t++) begin
            @(negedge clk);
            if (frame_busy) h = cyc;
        end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL to_grant: got %0d expected 0", cur_src); end
        @(posedge clk); #1;
        src_enable = 2'b11;
        push_frame(1, 8'h10, 11);
        for (int t = 0; t < 40 && e < 0; t++) begin
            @(negedge clk);
            if (frame_err) e = cyc;
        end
        q0.delete();
        n_checks++; if (h < 0 || e - h != 16) begin n_fail++; $display("FAIL to_delay: got %0d cycles expected 16", e - h); end
        wait_out(12, 100);
        repeat (3) @(negedge clk);
        n_checks++; if (out_q.size() != 12) begin n_fail++; $display("FAIL to_count: got %0d beats expected 12", out_q.size()); end
        for (int k = 0; k < 12; k++) begin
            beat_t got, exp;
            got = (k < out_q.size()) ? out_q[k] : '0;
            exp = exp_beat(8'h10, 11, k);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL to_beat k%0d: got %h expected %h", k, got, exp); end
        end
        n_checks++; if (cur_src !== 2'd1) begin n_fail++; $display("FAIL to_regrant: got %0d expected 1", cur_src); end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL to_err_count: got %0d pulses expected 1", err_cnt); end
    endtask

    task automatic test_backpressure;
        logic       prev_stall;
        logic [11:0] held;
        prev_stall = 1'b0; held = '0;
        out_q.delete(); out_cyc.delete(); err_cnt = 0;
        push_frame(0, 8'h00, 11);
        for (int t = 0; t < 300 && out_q.size() < 12; t++) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if ({m_valid, m_data, m_sof, m_eof, m_eol} !== held) begin
                    n_fail++; $display("FAIL bp_hold: got %h expected %h", {m_valid, m_data, m_sof, m_eof, m_eol}, held);
                end
            end
            prev_stall = m_valid && !m_ready;
            held = {m_valid, m_data, m_sof, m_eof, m_eol};
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (out_q.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 12", out_q.size()); end
        for (int k = 0; k < 12; k++) begin
            beat_t got, exp;
            got = (k < out_q.size()) ? out_q[k] : '0;
            exp = exp_beat(8'h00, 11, k);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL bp_beat k%0d: got %h expected %h", k, got, exp); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL bp_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_enable_mask;
        bit granted;
        granted = 1'b0;
        out_q.delete(); out_cyc.delete(); err_cnt = 0;
        push_frame(1, 8'h10, 11); push_frame(1, 8'h10, 11);
        push_frame(0, 8'h00, 11); push_frame(0, 8'h00, 11);
        for (int t = 0; t < 20 && !granted; t++) begin
            @(negedge clk);
            granted = frame_busy && (cur_src == 2'd1);
        end
        repeat (4) @(posedge clk);
        #1;
        src_enable = 2'b01;
        wait_out(36, 300);
        repeat (20) @(negedge clk);
        n_checks++; if (out_q.size() != 36) begin n_fail++; $display("FAIL en_count: got %0d beats expected 36", out_q.size()); end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 12; k++) begin
                beat_t got, exp;
                got = (f*12 + k < out_q.size()) ? out_q[f*12 + k] : '0;
                exp = exp_beat((f == 0) ? 8'h10 : 8'h00, 11, k);
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL en_beat f%0d k%0d: got %h expected %h", f, k, got, exp); end
            end
        end
        n_checks++; if (q1.size() != 12) begin n_fail++; $display("FAIL en_src1_left: got %0d beats expected 12", q1.size()); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL en_cur_src: got %0d expected 0", cur_src); end
        q1.delete();
        @(posedge clk); #1;
        src_enable = 2'b11;
    endtask

    task automatic test_reset_mid_frame;
        out_q.delete(); out_cyc.delete(); err_cnt = 0;
        push_frame(0, 8'h00, 11);
        wait_out(5, 100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid: got %b expected 0", m_valid); end
        n_checks++; if ({m_data, m_sof, m_eof, m_eol} !== 11'h000) begin n_fail++; $display("FAIL rmid_m_beat: got %h expected 000", {m_data, m_sof, m_eof, m_eol}); end
        n_checks++; if (cur_src !== 2'd1) begin n_fail++; $display("FAIL rmid_cur_src: got %0d expected 1", cur_src); end
        n_checks++; if ({frame_busy, frame_err} !== 2'b00) begin n_fail++; $display("FAIL rmid_status: got %b expected 00", {frame_busy, frame_err}); end
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_q.delete(); out_cyc.delete();
        push_frame(0, 8'h00, 11);
        push_frame(1, 8'h10, 11);
        wait_out(24, 200);
        n_checks++; if (out_q.size() != 24) begin n_fail++; $display("FAIL rmid_count: got %0d beats expected 24", out_q.size()); end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 12; k++) begin
                beat_t got, exp;
                got = (f*12 + k < out_q.size()) ? out_q[f*12 + k] : '0;
                exp = exp_beat((f == 0) ? 8'h00 : 8'h10, 11, k);
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL rmid_beat f%0d k%0d: got %h expected %h", f, k, got, exp); end
            end
        end
    endtask

    task automatic test_single_and_restart;
        beat_t exp_q[$];
        out_q.delete(); out_cyc.delete(); err_cnt = 0;
        repeat (3) @(negedge clk);
        q0.push_back('{8'h40, 1'b1, 1'b1, 1'b1});
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        n_checks++; if ({m_valid, m_data, m_sof, m_eof, m_eol} !== {1'b1, 8'h40, 3'b111}) begin
            n_fail++; $display("FAIL single_beat: got %h expected %h", {m_valid, m_data, m_sof, m_eof, m_eol}, {1'b1, 8'h40, 3'b111});
        end
        n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", frame_busy); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL single_err: got %0d pulses expected 0", err_cnt); end
        exp_q = '{'{8'h50, 1'b1, 1'b0, 1'b0}, '{8'h51, 1'b0, 1'b1, 1'b0}, '{8'h52, 1'b1, 1'b0, 1'b0},
                  '{8'h53, 1'b0, 1'b0, 1'b1}, '{8'h54, 1'b0, 1'b1, 1'b1}};
        foreach (exp_q[i]) q0.push_back(exp_q[i]);
        wait_out(6, 60);
        repeat (3) @(negedge clk);
        n_checks++; if (out_q.size() != 6) begin n_fail++; $display("FAIL restart_count: got %0d beats expected 6", out_q.size()); end
        for (int k = 0; k < 5; k++) begin
            beat_t got;
            got = (k + 1 < out_q.size()) ? out_q[k + 1] : '0;
            n_checks++;
            if (got !== exp_q[k]) begin n_fail++; $display("FAIL restart_beat k%0d: got %h expected %h", k, got, exp_q[k]); end
        end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL restart_err: got %0d pulses expected 1", err_cnt); end
        n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got %b expected 0", frame_busy); end
    endtask

    initial begin
        rst = 1'b1; src_enable = 2'b11; m_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_hunt_drop();
        test_hunt_timeout();
        test_backpressure();
        test_enable_mask();
        test_reset_mid_frame();
        test_single_and_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
